// File: rtl/wb_bus_arbiter_if.sv
// Wishbone bus bundle between three masters, the arbiter and one slave.
// Per-master fields are packed with master i at [i*W +: W].
interface wb_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int SEL_W = DATA_W / 8;

    logic [2:0]          m_cyc;
    logic [2:0]          m_stb;
    logic [2:0]          m_we;
    logic [3*ADDR_W-1:0] m_adr;
    logic [3*DATA_W-1:0] m_dat_w;
    logic [3*SEL_W-1:0]  m_sel;
    logic [DATA_W-1:0]   m_dat_r;
    logic [2:0]          m_ack;
    logic [2:0]          m_err;

    logic                s_cyc;
    logic                s_stb;
    logic                s_we;
    logic [ADDR_W-1:0]   s_adr;
    logic [DATA_W-1:0]   s_dat_w;
    logic [SEL_W-1:0]    s_sel;
    logic [DATA_W-1:0]   s_dat_r;
    logic                s_ack;
    logic                s_err;

    modport arbiter (
        input  m_cyc, m_stb, m_we, m_adr, m_dat_w, m_sel,
        output m_dat_r, m_ack, m_err,
        output s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel,
        input  s_dat_r, s_ack, s_err
    );

    modport master (
        output m_cyc, m_stb, m_we, m_adr, m_dat_w, m_sel,
        input  m_dat_r, m_ack, m_err
    );

    modport slave (
        input  s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel,
        output s_dat_r, s_ack, s_err
    );
endinterface

// File: rtl/wb_bus_arbiter.sv
// Round-robin three-master Wishbone arbiter: ownership held for the whole
// cyc period, slave stalls longer than TIMEOUT cycles are aborted with m_err.
module wb_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    wb_bus_arbiter_if.arbiter     bus,
    output logic [2:0]            grant,
    output logic                  timeout_pulse
);
    localparam int          SEL_W   = DATA_W / 8;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    logic [2:0]  grant_q, grant_d;
    logic [1:0]  last_q, last_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        abort_q, abort_d;

    logic        owned_s;
    logic        keep_s;
    logic [1:0]  g_s;
    logic [2:0]  pick_s;
    logic        s_stb_s;

    function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
        logic [1:0] idx;
        case (oh)
            3'b010:  idx = 2'd1;
            3'b100:  idx = 2'd2;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Returns {found, index}; search order is last+1, last+2, last+3 (mod 3).
    function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        idx = last;
        for (int k = 0; k < 3; k++) begin
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            if (!res[2] && req[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Ownership and round-robin arbitration.
    always_comb begin
        owned_s = |grant_q;
        g_s     = onehot_to_idx(grant_q);
        keep_s  = owned_s && bus.m_cyc[g_s];
        pick_s  = rr_pick(bus.m_cyc, last_q);
        grant_d = grant_q;
        last_d  = last_q;
        if (keep_s) begin
            grant_d = grant_q;
            last_d  = last_q;
        end else if (pick_s[2]) begin
            grant_d = 3'b001 << pick_s[1:0];
            last_d  = pick_s[1:0];
        end else begin
            grant_d = 3'b000;
            last_d  = last_q;
        end
    end

    // Slave-side mux; the abort cycle withdraws cyc/stb from the slave.
    always_comb begin
        bus.s_cyc   = 1'b0;
        s_stb_s     = 1'b0;
        bus.s_we    = 1'b0;
        bus.s_adr   = {ADDR_W{1'b0}};
        bus.s_dat_w = {DATA_W{1'b0}};
        bus.s_sel   = {SEL_W{1'b0}};
        if (owned_s) begin
            bus.s_cyc   = bus.m_cyc[g_s] && !abort_q;
            s_stb_s     = bus.m_stb[g_s] && !abort_q;
            bus.s_we    = bus.m_we[g_s];
            bus.s_adr   = bus.m_adr[g_s*ADDR_W +: ADDR_W];
            bus.s_dat_w = bus.m_dat_w[g_s*DATA_W +: DATA_W];
            bus.s_sel   = bus.m_sel[g_s*SEL_W +: SEL_W];
        end else begin
            bus.s_cyc   = 1'b0;
            s_stb_s     = 1'b0;
        end
        bus.s_stb   = s_stb_s;
        bus.m_dat_r = bus.s_dat_r;
    end

    // Response routing to the owner; a timeout forces err and masks the slave.
    always_comb begin
        bus.m_ack = 3'b000;
        bus.m_err = 3'b000;
        if (owned_s && abort_q) begin
            bus.m_err = grant_q;
        end else if (owned_s) begin
            bus.m_ack = {3{bus.s_ack}} & grant_q;
            bus.m_err = {3{bus.s_err}} & grant_q;
        end else begin
            bus.m_ack = 3'b000;
            bus.m_err = 3'b000;
        end
    end

    // Stall counter and abort detection.
    always_comb begin
        wait_cnt_d = 16'd0;
        abort_d    = 1'b0;
        if (owned_s && s_stb_s && !bus.s_ack && !bus.s_err) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
            abort_d    = keep_s && (wait_cnt_q == TO_LAST);
        end else begin
            wait_cnt_d = 16'd0;
            abort_d    = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q    <= 3'b000;
            last_q     <= 2'd2;
            wait_cnt_q <= 16'd0;
            abort_q    <= 1'b0;
        end else begin
            grant_q    <= grant_d;
            last_q     <= last_d;
            wait_cnt_q <= wait_cnt_d;
            abort_q    <= abort_d;
        end
    end

    assign grant         = grant_q;
    assign timeout_pulse = abort_q;
endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed scenario tasks plus a randomized run against a behavioural model.
module tb_wb_bus_arbiter;
    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] grant;
    logic       timeout_pulse;

    int tests_run    = 0;
    int tests_failed = 0;

    wb_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    wb_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .bus(bus), .grant(grant), .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    // model state: owner index (-1 = idle), most recent owner, stall count, abort flag
    int   mdl_owner;
    int   mdl_last;
    int   mdl_wait;
    bit   mdl_abort;
    logic [2:0]  exp_grant, exp_ack, exp_err;
    logic        exp_cyc, exp_stb, exp_we, exp_to;
    logic [31:0] exp_adr, exp_dat;
    logic [3:0]  exp_sel;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.m_cyc = 3'b000; bus.m_stb = 3'b000; bus.m_we = 3'b000;
        bus.m_adr = 96'h0; bus.m_dat_w = 96'h0; bus.m_sel = 12'h0;
        bus.s_dat_r = 32'h0; bus.s_ack = 1'b0; bus.s_err = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic model_eval();
        exp_grant = 3'b000; exp_ack = 3'b000; exp_err = 3'b000;
        exp_cyc = 1'b0; exp_stb = 1'b0; exp_we = 1'b0; exp_to = mdl_abort;
        exp_adr = 32'h0; exp_dat = 32'h0; exp_sel = 4'h0;
        if (mdl_owner >= 0) begin
            exp_grant[mdl_owner] = 1'b1;
            exp_we  = bus.m_we[mdl_owner];
            exp_adr = bus.m_adr[mdl_owner*32 +: 32];
            exp_dat = bus.m_dat_w[mdl_owner*32 +: 32];
            exp_sel = bus.m_sel[mdl_owner*4 +: 4];
            if (mdl_abort) begin
                exp_err[mdl_owner] = 1'b1;
            end else begin
                exp_cyc = bus.m_cyc[mdl_owner];
                exp_stb = bus.m_stb[mdl_owner];
                exp_ack[mdl_owner] = bus.s_ack;
                exp_err[mdl_owner] = bus.s_err;
            end
        end
    endtask

    task automatic model_advance();
        bit stalled;
        bit nxt_abort;
        int w;
        if (rst) begin
            mdl_owner = -1; mdl_last = 2; mdl_wait = 0; mdl_abort = 1'b0;
        end else begin
            stalled   = (mdl_owner >= 0) && exp_stb && !bus.s_ack && !bus.s_err;
            nxt_abort = stalled && bus.m_cyc[mdl_owner] && (mdl_wait == TO - 1);
            mdl_wait  = stalled ? mdl_wait + 1 : 0;
            if (mdl_owner < 0 || !bus.m_cyc[mdl_owner]) begin
                w = -1;
                for (int k = 1; k <= 3; k++) begin
                    if (w < 0 && bus.m_cyc[(mdl_last + k) % 3]) w = (mdl_last + k) % 3;
                end
                mdl_owner = w;
                if (w >= 0) mdl_last = w;
            end
            mdl_abort = nxt_abort;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        bus.s_dat_r = 32'hA5A5_5A5A;
        bus.s_ack = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        tests_run++;
        if ({grant, bus.s_cyc, bus.s_stb, bus.s_we, bus.s_sel, bus.m_ack, bus.m_err, timeout_pulse} !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %h expected 0000",
                     {grant, bus.s_cyc, bus.s_stb, bus.s_we, bus.s_sel, bus.m_ack, bus.m_err, timeout_pulse});
        end
        tests_run++;
        if ({bus.s_adr, bus.s_dat_w} !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_addr_data: got %h expected 0", {bus.s_adr, bus.s_dat_w});
        end
        tests_run++;
        if (bus.m_dat_r !== 32'hA5A5_5A5A) begin
            tests_failed++;
            $display("FAIL reset_dat_r: got %h expected a5a55a5a", bus.m_dat_r);
        end
        next_cycle();
        rst = 1'b0;
        bus.s_ack = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        next_cycle();
        bus.m_cyc = 3'b010; bus.m_stb = 3'b010; bus.m_we = 3'b010;
        bus.m_adr[32 +: 32] = 32'h0000_1000;
        bus.m_dat_w[32 +: 32] = 32'hDEAD_BEEF;
        bus.m_sel[4 +: 4] = 4'hF;
        @(negedge clk);
        tests_run++;
        if ({grant, bus.s_cyc} !== 4'h0) begin
            tests_failed++;
            $display("FAIL single_request_cycle: got %h expected 0", {grant, bus.s_cyc});
        end
        next_cycle();
        @(negedge clk);
        tests_run++;
        if ({grant, bus.s_cyc, bus.s_stb, bus.s_we, bus.s_adr, bus.s_dat_w, bus.s_sel, bus.m_ack} !==
            {3'b010, 1'b1, 1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 3'b000}) begin
            tests_failed++;
            $display("FAIL single_grant: grant %b adr %h dat %h we %b got, expected 010 00001000 deadbeef 1",
                     grant, bus.s_adr, bus.s_dat_w, bus.s_we);
        end
        next_cycle();
        bus.s_ack = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({bus.m_ack, bus.m_err} !== 6'b010_000) begin
            tests_failed++;
            $display("FAIL single_ack: got ack %b err %b expected 010 000", bus.m_ack, bus.m_err);
        end
        next_cycle();
        bus.s_ack = 1'b0;
        clear_inputs();
        @(negedge clk);
        tests_run++;
        if (bus.m_ack !== 3'b000) begin
            tests_failed++;
            $display("FAIL single_ack_once: got %b expected 000", bus.m_ack);
        end
        next_cycle();
        @(negedge clk);
        tests_run++;
        if (grant !== 3'b000) begin
            tests_failed++;
            $display("FAIL single_release: got %b expected 000", grant);
        end
        next_cycle();
    endtask

    task automatic test_simultaneous();
        logic [2:0] oh;
        do_reset();
        bus.m_cyc = 3'b111; bus.m_stb = 3'b111;
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            oh = 3'b001 << i;
            bus.s_ack = 1'b1;
            @(negedge clk);
            tests_run++;
            if ({grant, bus.m_ack} !== {oh, oh}) begin
                tests_failed++;
                $display("FAIL simultaneous_order_%0d: got grant %b ack %b expected %b", i, grant, bus.m_ack, oh);
            end
            next_cycle();
            bus.s_ack = 1'b0;
            bus.m_cyc[i] = 1'b0; bus.m_stb[i] = 1'b0;
            @(negedge clk);
            tests_run++;
            if (grant !== oh) begin
                tests_failed++;
                $display("FAIL simultaneous_hold_%0d: got %b expected %b", i, grant, oh);
            end
            next_cycle();
        end
        @(negedge clk);
        tests_run++;
        if (grant !== 3'b000) begin
            tests_failed++;
            $display("FAIL simultaneous_idle: got %b expected 000", grant);
        end
        next_cycle();
    endtask

    task automatic test_fairness();
        logic [2:0] oh;
        int idx;
        do_reset();
        bus.m_cyc = 3'b101; bus.m_stb = 3'b101;
        next_cycle();
        for (int n = 0; n < 6; n++) begin
            idx = (n % 2 == 0) ? 0 : 2;
            oh  = 3'b001 << idx;
            bus.s_ack = 1'b1;
            @(negedge clk);
            tests_run++;
            if (grant !== oh) begin
                tests_failed++;
                $display("FAIL fairness_%0d: got %b expected %b", n, grant, oh);
            end
            next_cycle();
            bus.s_ack = 1'b0;
            bus.m_cyc[idx] = 1'b0; bus.m_stb[idx] = 1'b0;
            next_cycle();
            bus.m_cyc[idx] = 1'b1; bus.m_stb[idx] = 1'b1;
        end
        clear_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_lock();
        do_reset();
        bus.m_cyc = 3'b101; bus.m_stb = 3'b100;
        next_cycle();
        for (int t = 0; t < 3; t++) begin
            bus.m_stb[0] = 1'b1;
            bus.s_ack = 1'b1;
            @(negedge clk);
            tests_run++;
            if ({grant, bus.m_ack} !== 6'b001_001) begin
                tests_failed++;
                $display("FAIL lock_xfer_%0d: got grant %b ack %b expected 001 001", t, grant, bus.m_ack);
            end
            next_cycle();
            bus.s_ack = 1'b0;
            bus.m_stb[0] = 1'b0;
            next_cycle();
        end
        bus.m_cyc[0] = 1'b0;
        @(negedge clk);
        tests_run++;
        if (grant !== 3'b001) begin
            tests_failed++;
            $display("FAIL lock_drop_cycle: got %b expected 001", grant);
        end
        next_cycle();
        @(negedge clk);
        tests_run++;
        if (grant !== 3'b100) begin
            tests_failed++;
            $display("FAIL lock_handover: got %b expected 100", grant);
        end
        clear_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_timeout();
        do_reset();
        bus.m_cyc = 3'b100; bus.m_stb = 3'b100;
        bus.m_adr[64 +: 32] = 32'h0000_4000;
        next_cycle();
        for (int j = 0; j < TO; j++) begin
            @(negedge clk);
            tests_run++;
            if ({grant, bus.s_stb, bus.m_err, timeout_pulse} !== {3'b100, 1'b1, 3'b000, 1'b0}) begin
                tests_failed++;
                $display("FAIL timeout_wait_%0d: got grant %b stb %b err %b pulse %b expected 100 1 000 0",
                         j, grant, bus.s_stb, bus.m_err, timeout_pulse);
            end
            next_cycle();
        end
        bus.s_ack = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({bus.m_err, bus.m_ack, timeout_pulse, bus.s_cyc, bus.s_stb} !== {3'b100, 3'b000, 1'b1, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL timeout_abort: got err %b ack %b pulse %b cyc %b stb %b expected 100 000 1 0 0",
                     bus.m_err, bus.m_ack, timeout_pulse, bus.s_cyc, bus.s_stb);
        end
        next_cycle();
        bus.s_ack = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({grant, timeout_pulse, bus.m_err, bus.s_stb} !== {3'b100, 1'b0, 3'b000, 1'b1}) begin
            tests_failed++;
            $display("FAIL timeout_after: got grant %b pulse %b err %b stb %b expected 100 0 000 1",
                     grant, timeout_pulse, bus.m_err, bus.s_stb);
        end
        clear_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.m_cyc = 3'b010; bus.m_stb = 3'b010; bus.m_we = 3'b010;
        bus.m_adr[32 +: 32] = 32'h0000_2000;
        bus.m_dat_w[32 +: 32] = 32'h1234_5678;
        bus.m_sel[4 +: 4] = 4'h3;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        bus.m_cyc = 3'b011; bus.m_stb = 3'b011;
        @(negedge clk);
        tests_run++;
        if (grant !== 3'b010) begin
            tests_failed++;
            $display("FAIL reset_mid_before: got %b expected 010", grant);
        end
        next_cycle();
        rst = 1'b0;
        bus.s_ack = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({grant, bus.s_cyc, bus.s_stb, bus.s_we, bus.s_sel, bus.s_adr, bus.s_dat_w, bus.m_ack} !== 81'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_cleared: got grant %b cyc %b stb %b adr %h ack %b expected all 0",
                     grant, bus.s_cyc, bus.s_stb, bus.s_adr, bus.m_ack);
        end
        next_cycle();
        bus.s_ack = 1'b0;
        @(negedge clk);
        tests_run++;
        if (grant !== 3'b001) begin
            tests_failed++;
            $display("FAIL reset_mid_first_winner: got %b expected 001", grant);
        end
        clear_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_random();
        logic [2:0] want;
        do_reset();
        mdl_owner = -1; mdl_last = 2; mdl_wait = 0; mdl_abort = 1'b0;
        want = 3'b000;
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < 3; i++) begin
                if (want[i] && $urandom_range(0, 7) == 0) want[i] = 1'b0;
                else if (!want[i] && $urandom_range(0, 3) == 0) want[i] = 1'b1;
            end
            bus.m_cyc   = want;
            bus.m_stb   = want & 3'($urandom);
            bus.m_we    = 3'($urandom);
            bus.m_adr   = {$urandom, $urandom, $urandom};
            bus.m_dat_w = {$urandom, $urandom, $urandom};
            bus.m_sel   = 12'($urandom);
            bus.s_dat_r = $urandom;
            bus.s_ack   = ($urandom_range(0, 2) == 0);
            bus.s_err   = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            model_eval();
            tests_run++;
            if ({grant, timeout_pulse, bus.s_cyc, bus.s_stb, bus.s_we, bus.s_sel, bus.s_adr, bus.s_dat_w,
                 bus.m_ack, bus.m_err, bus.m_dat_r} !==
                {exp_grant, exp_to, exp_cyc, exp_stb, exp_we, exp_sel, exp_adr, exp_dat,
                 exp_ack, exp_err, bus.s_dat_r}) begin
                tests_failed++;
                $display("FAIL random_c%0d: got grant %b to %b cyc %b stb %b ack %b err %b adr %h, expected %b %b %b %b %b %b %h",
                         c, grant, timeout_pulse, bus.s_cyc, bus.s_stb, bus.m_ack, bus.m_err, bus.s_adr,
                         exp_grant, exp_to, exp_cyc, exp_stb, exp_ack, exp_err, exp_adr);
            end
            model_advance();
            next_cycle();
        end
        rst = 1'b0;
        clear_inputs();
        next_cycle();
    endtask

    initial begin
        clear_inputs();
        next_cycle();
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_lock();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
